// File: rtl/wb_arbiter_if.sv
// Signal bundle between the MEM/WB latch, the mult/div unit, decode and the regfile write port.
// md_ready is a one-cycle pulse that is always accepted; md_stall=1 asks upstream to present a bubble.
interface wb_arbiter_if;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_dmem_data;
    logic [31:0] mem_pc_plus1;
    logic        mem_ovf;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    logic [4:0]  md_rd;
    logic        md_is_div;
    logic [4:0]  addr_readRegA;
    logic [4:0]  addr_readRegB;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrlwritereg;
    logic [31:0] data_write;
    logic        fwd_hitA;
    logic        fwd_hitB;
    logic        md_stall;
    logic        md_drop;

    modport slave (
        input  mem_valid, mem_inst, mem_alu_result, mem_dmem_data, mem_pc_plus1, mem_ovf,
        input  md_ready, md_result, md_exception, md_rd, md_is_div,
        input  addr_readRegA, addr_readRegB,
        output ctrl_writeEnable, ctrlwritereg, data_write, fwd_hitA, fwd_hitB, md_stall, md_drop
    );

    modport master (
        output mem_valid, mem_inst, mem_alu_result, mem_dmem_data, mem_pc_plus1, mem_ovf,
        output md_ready, md_result, md_exception, md_rd, md_is_div,
        output addr_readRegA, addr_readRegB,
        input  ctrl_writeEnable, ctrlwritereg, data_write, fwd_hitA, fwd_hitB, md_stall, md_drop
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: decodes the MEM/WB write, merges late mult/div results through a
// one-entry pending buffer into the single regfile write port, and reports bypass hits.
module wb_arbiter #(
    parameter logic [4:0] RSTATUS = 5'd30,
    parameter logic [4:0] RLINK   = 5'd31
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);
    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] FN_ADD  = 5'b00000;
    localparam logic [4:0] FN_SUB  = 5'b00001;
    localparam logic [4:0] FN_MUL  = 5'b00110;
    localparam logic [4:0] FN_DIV  = 5'b00111;

    logic [4:0]  opcode, rd, aluop;
    logic        pipe_we, pipe_hit, md_hit;
    logic [4:0]  pipe_dest, md_dest;
    logic [31:0] pipe_data, md_data;

    logic        we_q, we_n;
    logic [4:0]  reg_q, reg_n;
    logic [31:0] data_q, data_n;
    logic        buf_valid, buf_valid_n;
    logic [4:0]  buf_dest, buf_dest_n;
    logic [31:0] buf_data, buf_data_n;
    logic        drop_q, drop_n;

    assign opcode = bus.mem_inst[31:27];
    assign rd     = bus.mem_inst[26:22];
    assign aluop  = bus.mem_inst[6:2];

    always_comb begin
        pipe_we   = 1'b0;
        pipe_dest = 5'd0;
        pipe_data = 32'd0;
        if (bus.mem_valid) begin
            case (opcode)
                OP_R: begin
                    if (aluop != FN_MUL && aluop != FN_DIV) begin
                        pipe_we = 1'b1;
                        if (bus.mem_ovf && aluop == FN_ADD) begin
                            pipe_dest = RSTATUS;
                            pipe_data = 32'd1;
                        end else if (bus.mem_ovf && aluop == FN_SUB) begin
                            pipe_dest = RSTATUS;
                            pipe_data = 32'd3;
                        end else begin
                            pipe_dest = rd;
                            pipe_data = bus.mem_alu_result;
                        end
                    end
                end
                OP_ADDI: begin
                    pipe_we   = 1'b1;
                    pipe_dest = bus.mem_ovf ? RSTATUS : rd;
                    pipe_data = bus.mem_ovf ? 32'd2 : bus.mem_alu_result;
                end
                OP_LW: begin
                    pipe_we   = 1'b1;
                    pipe_dest = rd;
                    pipe_data = bus.mem_dmem_data;
                end
                OP_JAL: begin
                    pipe_we   = 1'b1;
                    pipe_dest = RLINK;
                    pipe_data = bus.mem_pc_plus1;
                end
                OP_SETX: begin
                    pipe_we   = 1'b1;
                    pipe_dest = RSTATUS;
                    pipe_data = {5'd0, bus.mem_inst[26:0]};
                end
                default: ;
            endcase
        end
    end

    // Writes to r0 are discarded before arbitration so they never occupy the port or the buffer.
    assign pipe_hit = pipe_we && (pipe_dest != 5'd0);
    assign md_dest  = bus.md_exception ? RSTATUS : bus.md_rd;
    assign md_data  = bus.md_exception ? (bus.md_is_div ? 32'd5 : 32'd4) : bus.md_result;
    assign md_hit   = bus.md_ready && (md_dest != 5'd0);

    always_comb begin
        we_n        = 1'b0;
        reg_n       = 5'd0;
        data_n      = 32'd0;
        buf_valid_n = buf_valid;
        buf_dest_n  = buf_dest;
        buf_data_n  = buf_data;
        drop_n      = drop_q;
        if (pipe_hit) begin
            we_n   = 1'b1;
            reg_n  = pipe_dest;
            data_n = pipe_data;
            if (md_hit) begin
                if (buf_valid) begin
                    drop_n = 1'b1;
                end else begin
                    buf_valid_n = 1'b1;
                    buf_dest_n  = md_dest;
                    buf_data_n  = md_data;
                end
            end
        end else if (buf_valid) begin
            // Drain the buffer; a simultaneous result takes the freed slot.
            we_n        = 1'b1;
            reg_n       = buf_dest;
            data_n      = buf_data;
            buf_valid_n = md_hit;
            if (md_hit) begin
                buf_dest_n = md_dest;
                buf_data_n = md_data;
            end
        end else if (md_hit) begin
            we_n   = 1'b1;
            reg_n  = md_dest;
            data_n = md_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q      <= 1'b0;
            reg_q     <= 5'd0;
            data_q    <= 32'd0;
            buf_valid <= 1'b0;
            buf_dest  <= 5'd0;
            buf_data  <= 32'd0;
            drop_q    <= 1'b0;
        end else begin
            we_q      <= we_n;
            reg_q     <= reg_n;
            data_q    <= data_n;
            buf_valid <= buf_valid_n;
            buf_dest  <= buf_dest_n;
            buf_data  <= buf_data_n;
            drop_q    <= drop_n;
        end
    end

    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrlwritereg     = reg_q;
    assign bus.data_write       = data_q;
    assign bus.md_stall         = buf_valid;
    assign bus.md_drop          = drop_q;
    assign bus.fwd_hitA = we_q && (reg_q == bus.addr_readRegA) && (bus.addr_readRegA != 5'd0);
    assign bus.fwd_hitB = we_q && (reg_q == bus.addr_readRegB) && (bus.addr_readRegB != 5'd0);
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_wb_arbiter;
    localparam int W = 38;  // {write_enable, dest[4:0], data[31:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if bus();
    wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [36:0]  pend_q[$];
    logic         exp_drop = 1'b0;
    logic [4:0]   last_dest = 5'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_inst(input logic [4:0] rd, input logic [4:0] fn);
        return {5'd0, rd, 15'd0, fn, 2'b00};
    endfunction

    function automatic logic [31:0] i_inst(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    // Model: what the pipeline instruction writes, per the writeback rules.
    function automatic logic [W-1:0] pipe_model(input logic v, input logic [31:0] inst,
        input logic [31:0] alu, input logic [31:0] dmem, input logic [31:0] pc1, input logic ovf);
        logic [4:0]  op, rd, fn, dest;
        logic [31:0] data;
        logic        wr;
        op = inst[31:27]; rd = inst[26:22]; fn = inst[6:2];
        wr = 1'b1; dest = rd; data = alu;
        if (!v) wr = 1'b0;
        else if (op == 5'd0) begin
            if (fn == 5'd6 || fn == 5'd7) wr = 1'b0;
            else if (ovf && fn == 5'd0) begin dest = 5'd30; data = 1; end
            else if (ovf && fn == 5'd1) begin dest = 5'd30; data = 3; end
        end
        else if (op == 5'd5) begin
            if (ovf) begin dest = 5'd30; data = 2; end
        end
        else if (op == 5'd8) data = dmem;
        else if (op == 5'd3) begin dest = 5'd31; data = pc1; end
        else if (op == 5'd21) begin dest = 5'd30; data = {5'd0, inst[26:0]}; end
        else wr = 1'b0;
        if (!wr || dest == 5'd0) return '0;
        return {1'b1, dest, data};
    endfunction

    function automatic logic [W-1:0] md_model(input logic rdy, input logic [4:0] rd,
        input logic [31:0] res, input logic exc, input logic is_div);
        if (!rdy) return '0;
        if (exc) return {1'b1, 5'd30, is_div ? 32'd5 : 32'd4};
        if (rd == 5'd0) return '0;
        return {1'b1, rd, res};
    endfunction

    task automatic drive_idle();
        bus.mem_valid = 0; bus.mem_inst = 0; bus.mem_alu_result = 0; bus.mem_dmem_data = 0;
        bus.mem_pc_plus1 = 0; bus.mem_ovf = 0;
        bus.md_ready = 0; bus.md_result = 0; bus.md_exception = 0; bus.md_rd = 0; bus.md_is_div = 0;
        bus.addr_readRegA = 0; bus.addr_readRegB = 0;
    endtask

    task automatic drive_inst(input logic [31:0] inst, input logic [31:0] alu,
        input logic [31:0] dmem, input logic [31:0] pc1, input logic ovf);
        bus.mem_valid = 1; bus.mem_inst = inst; bus.mem_alu_result = alu;
        bus.mem_dmem_data = dmem; bus.mem_pc_plus1 = pc1; bus.mem_ovf = ovf;
    endtask

    task automatic drive_md(input logic [4:0] rd, input logic [31:0] res,
        input logic exc, input logic is_div);
        bus.md_ready = 1; bus.md_rd = rd; bus.md_result = res;
        bus.md_exception = exc; bus.md_is_div = is_div;
    endtask

    // Advance one clock: predict, clock, check, then return inputs to idle.
    task automatic cycle();
        logic [W-1:0] p, m, o, e;
        logic [4:0]   ea, eb;
        p = pipe_model(bus.mem_valid, bus.mem_inst, bus.mem_alu_result, bus.mem_dmem_data,
                       bus.mem_pc_plus1, bus.mem_ovf);
        m = md_model(bus.md_ready, bus.md_rd, bus.md_result, bus.md_exception, bus.md_is_div);
        o = '0;
        if (!rst) begin
            pend_q.delete();
            exp_drop = 1'b0;
        end else begin
            if (p[37]) o = p;
            else if (pend_q.size() > 0) o = {1'b1, pend_q.pop_front()};
            if (m[37]) begin
                if (!o[37]) o = m;
                else if (pend_q.size() == 0) pend_q.push_back(m[36:0]);
                else exp_drop = 1'b1;
            end
        end
        exp_q.push_back(o);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        ea = bus.addr_readRegA;
        eb = bus.addr_readRegB;
        chk("we",    32'(bus.ctrl_writeEnable), 32'(e[37]));
        chk("reg",   32'(bus.ctrlwritereg),     32'(e[36:32]));
        chk("data",  bus.data_write,            e[31:0]);
        chk("stall", 32'(bus.md_stall),         32'(pend_q.size() == 1));
        chk("drop",  32'(bus.md_drop),          32'(exp_drop));
        chk("fwdA",  32'(bus.fwd_hitA),         32'(e[37] && e[36:32] == ea && ea != 0));
        chk("fwdB",  32'(bus.fwd_hitB),         32'(e[37] && e[36:32] == eb && eb != 0));
        if (e[37]) last_dest = e[36:32];
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        cycle(); cycle();
        rst = 1'b1;

        // addi r5 with bypass on read port B
        drive_inst(i_inst(5'd5, 5'd5), 32'h12, 0, 0, 0); bus.addr_readRegB = 5'd5; cycle();
        drive_inst(i_inst(5'd3, 5'd7), 0, 0, 32'h40, 0); bus.addr_readRegA = 5'd31; cycle();
        drive_inst({5'd21, 27'h7}, 0, 0, 0, 0); cycle();
        drive_inst(r_inst(5'd4, 5'd0), 32'h99, 0, 0, 1); bus.addr_readRegA = 5'd4; cycle();
        drive_inst(r_inst(5'd4, 5'd1), 32'h99, 0, 0, 1); cycle();
        drive_inst(i_inst(5'd5, 5'd6), 32'h1, 0, 0, 1); cycle();
        drive_inst(r_inst(5'd8, 5'd6), 32'h5, 0, 0, 0); cycle();
        // lw collides with a mult/div result, which drains on the following bubble
        drive_inst(i_inst(5'd8, 5'd3), 0, 32'hDEAD, 0, 0); drive_md(5'd9, 32'hABCD, 0, 0); cycle();
        bus.addr_readRegA = 5'd9; cycle();
        drive_md(5'd12, 32'h1, 1, 1); cycle();
        drive_md(5'd12, 32'h1, 1, 0); cycle();
        // full buffer plus pipeline write loses the second result
        drive_inst(i_inst(5'd8, 5'd4), 0, 32'h44, 0, 0); drive_md(5'd9, 32'h99, 0, 0); cycle();
        drive_inst(i_inst(5'd5, 5'd6), 32'h66, 0, 0, 0); drive_md(5'd10, 32'hAA, 0, 0); cycle();
        cycle(); cycle();
        // r0 writes never issue and let the buffer drain
        drive_inst(i_inst(5'd5, 5'd0), 32'h77, 0, 0, 0); cycle();
        drive_inst(i_inst(5'd8, 5'd2), 0, 32'h22, 0, 0); drive_md(5'd11, 32'hBB, 0, 0); cycle();
        drive_inst(i_inst(5'd5, 5'd0), 32'h77, 0, 0, 0); drive_md(5'd13, 32'hCC, 0, 0); cycle();
        // reset with a full buffer discards it
        drive_inst(i_inst(5'd8, 5'd2), 0, 32'h22, 0, 0); drive_md(5'd14, 32'hEE, 0, 0); cycle();
        rst = 1'b0; cycle();
        rst = 1'b1; cycle(); cycle();

        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [4:0] op, fn;
            sel = $urandom_range(0, 6);
            case (sel)
                0: op = 5'd0; 1: op = 5'd5; 2: op = 5'd8; 3: op = 5'd3; 4: op = 5'd21;
                5: op = 5'd0; default: op = 5'($urandom_range(0, 31));
            endcase
            fn = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 6) begin
                drive_inst({op, 5'($urandom_range(0, 31)), 15'($urandom), fn, 2'($urandom)},
                           $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) == 0));
            end
            if ($urandom_range(0, 9) < 4)
                drive_md(5'($urandom_range(0, 31)), $urandom,
                         1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            bus.addr_readRegA = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
            bus.addr_readRegB = ($urandom_range(0, 1) == 1) ? last_dest : 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage of the 5-stage pipeline; the write-side counterpart of decode, which only reads register addresses.
- Registers the MEM/WB latch and decodes which register each instruction writes.
- Selects the write data and merges late results from the multi-cycle mult/div unit into the single regfile write port.
- Drives the regfile write port and returns bypass hits for decode's two read addresses.

Parameters:
- RSTATUS, 30, register written on exceptions and by setx.
- RLINK, 31, register written by jal.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- mem_valid  in  1  MEM/WB latch holds a real instruction; 0 means bubble.
- mem_inst  in  32  instruction in MEM/WB; opcode [31:27], rd [26:22], ALUop [6:2], target [26:0].
- mem_alu_result  in  32  ALU output.
- mem_dmem_data  in  32  load data.
- mem_pc_plus1  in  32  PC+1 of the instruction.
- mem_ovf  in  1  ALU overflow for add/sub/addi.
- md_ready  in  1  single-cycle pulse: mult/div result available.
- md_result  in  32  mult/div result.
- md_exception  in  1  mult overflow or divide-by-zero, qualified by md_ready.
- md_rd  in  5  destination captured at mult/div issue.
- md_is_div  in  1  result is from div.
- addr_readRegA  in  5  decode read address A.
- addr_readRegB  in  5  decode read address B.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrlwritereg  out  5  regfile write address.
- data_write  out  32  regfile write data.
- fwd_hitA  out  1  write in flight matches addr_readRegA.
- fwd_hitB  out  1  write in flight matches addr_readRegB.
- md_stall  out  1  pending buffer full; upstream must present a bubble.
- md_drop  out  1  sticky: a mult/div result was lost.

Behaviour:
- Reset: when rst=0 at a clk edge, all outputs go to 0 and the pending buffer is emptied. This applies mid-operation; a buffered result is discarded.
- Pipeline write decode, only when mem_valid=1:
  - R-type (00000), ALUop not mul/div: dest rd, data mem_alu_result.
  - addi (00101): dest rd, data mem_alu_result.
  - lw (01000): dest rd, data mem_dmem_data.
  - jal (00011): dest RLINK, data mem_pc_plus1.
  - setx (10101): dest RSTATUS, data zero-extended target[26:0].
  - Overflow: R-add with mem_ovf writes RSTATUS=1; addi with mem_ovf writes RSTATUS=2; R-sub with mem_ovf writes RSTATUS=3. The normal rd write is suppressed.
  - R-type mul/div (ALUop 00110/00111) and all other opcodes: no pipeline write.
- Mult/div write:
  - Normal: dest md_rd, data md_result.
  - If md_exception: dest RSTATUS, data 4 (mult) or 5 (div).
- Arbitration, evaluated each cycle to produce the next registered write:
  - Pipeline write present: it wins. Any md_ready in the same cycle goes into the 1-entry pending buffer.
  - No pipeline write, buffer full: buffer drains. A simultaneous md_ready is refilled into the buffer in the same cycle.
  - No pipeline write, buffer empty, md_ready=1: the mult/div result writes directly.
  - md_ready while the buffer is full and a pipeline write is present: the new mult/div result is dropped and md_drop is set. md_drop clears only on reset.
- Destination 0: a write to r0 is never issued. It consumes no slot, so a pending buffer may drain in that cycle.
- Latency: exactly 1 cycle. ctrl_writeEnable, ctrlwritereg and data_write are registered and valid the cycle after the inputs are sampled. When ctrl_writeEnable=0, ctrlwritereg and data_write are 0.
- md_stall: combinational; equals buffer-full.
- Forwarding:
  - fwd_hitA = ctrl_writeEnable and (ctrlwritereg == addr_readRegA) and (addr_readRegA != 0).
  - fwd_hitB: same rule with addr_readRegB.
  - Both are combinational from the registered outputs; forwarded data is data_write.
- Data widths: all data is 32 bits; exception codes are zero-extended.

Test Plan:
- addi r5 (mem_inst rd=5, opcode 00101), mem_alu_result=0x12, mem_ovf=0 -> next cycle ctrl_writeEnable=1, ctrlwritereg=5, data_write=0x12. With addr_readRegB=5 in that cycle, fwd_hitB=1.
- jal with mem_pc_plus1=0x40 -> write r31=0x40. setx with target=0x7 -> write r30=7. Add with mem_ovf=1 -> write r30=1, no rd write.
- lw r3 and md_ready (md_rd=9, result 0xABCD) in the same cycle -> cycle+1 writes r3 with load data and md_stall=1. With a bubble next, cycle+2 writes r9=0xABCD and md_stall=0.
- md_ready with md_exception, md_is_div=1, pipeline bubble -> write r30=5 next cycle. Same with md_is_div=0 -> write r30=4.
- Buffer full, pipeline write present, second md_ready -> md_drop=1 and stays 1; buffered result intact and written on the next bubble.
- Write to r0 (addi rd=0) -> ctrl_writeEnable=0. With addr_readRegA=0, fwd_hitA=0. rst=0 while the buffer is full -> all outputs 0 next cycle, no later drain.
